// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_if
// Purpose  : Request/response and data-memory bus bundle for lsu_mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  mem_req;
    logic                  mem_rdwrbar;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    // Environment side: the core issuing requests plus the memory returning data
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_rdwrbar, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_rdwrbar, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : RV32 load/store controller for a single-port word memory with
//            sub-word loads (sign/zero extend) and read-modify-write stores.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int WORDS         = 4096,
    parameter int ADDR_WIDTH    = 24,
    parameter int ACCESS_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lsu_mem_ctrl_if.slave      bus
);
    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic                  r_we,         w_we_nxt;
    logic [2:0]            r_funct3,     w_funct3_nxt;
    logic [1:0]            r_lane,       w_lane_nxt;
    logic [ADDR_WIDTH-1:0] r_word_addr,  w_word_addr_nxt;
    logic [15:0]           r_wdata,      w_wdata_nxt;
    logic [CNT_W-1:0]      r_cnt,        w_cnt_nxt;
    logic [31:0]           r_mem_wdata,  w_mem_wdata_nxt;
    logic [31:0]           r_resp_rdata, w_resp_rdata_nxt;
    logic                  r_resp_err,   w_resp_err_nxt;
    logic                  w_req_err;

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lane);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            c_f3_b:  load_ext = {{24{b[7]}}, b};
            c_f3_bu: load_ext = {24'b0, b};
            c_f3_h:  load_ext = {{16{h[15]}}, h};
            c_f3_hu: load_ext = {16'b0, h};
            default: load_ext = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] wd,
                                                input logic        is_half,
                                                input logic [1:0]  lane);
        logic [31:0] m;
        m = word;
        if (is_half) m[{lane[1], 4'b0000} +: 16] = wd;
        else         m[{lane, 3'b000} +: 8]      = wd[7:0];
        store_merge = m;
    endfunction

    // Every rejection is decided from the request alone, so the error path never touches memory
    always_comb begin
        w_req_err = 1'b0;
        case (bus.req_funct3)
            c_f3_b, c_f3_bu: w_req_err = 1'b0;
            c_f3_h, c_f3_hu: w_req_err = bus.req_addr[0];
            c_f3_w:          w_req_err = (bus.req_addr[1:0] != 2'b00);
            default:         w_req_err = 1'b1;
        endcase
        if (bus.req_we && (bus.req_funct3 == c_f3_bu || bus.req_funct3 == c_f3_hu))
            w_req_err = 1'b1;
        if (32'(bus.req_addr[31:2]) >= 32'(WORDS))
            w_req_err = 1'b1;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_we_nxt         = r_we;
        w_funct3_nxt     = r_funct3;
        w_lane_nxt       = r_lane;
        w_word_addr_nxt  = r_word_addr;
        w_wdata_nxt      = r_wdata;
        w_cnt_nxt        = r_cnt;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_we_nxt        = bus.req_we;
                    w_funct3_nxt    = bus.req_funct3;
                    w_lane_nxt      = bus.req_addr[1:0];
                    w_word_addr_nxt = bus.req_addr[ADDR_WIDTH+1:2];
                    w_wdata_nxt     = bus.req_wdata[15:0];
                    if (w_req_err) begin
                        w_state_nxt      = RESP;
                        w_resp_rdata_nxt = 32'b0;
                        w_resp_err_nxt   = 1'b1;
                    end else if (bus.req_we && bus.req_funct3 == c_f3_w) begin
                        w_state_nxt     = WR;
                        w_mem_wdata_nxt = bus.req_wdata;
                    end else begin
                        w_state_nxt = RD_WAIT;
                        w_cnt_nxt   = CNT_W'(ACCESS_CYCLES);
                    end
                end
            end
            RD_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    if (r_we) begin
                        w_state_nxt     = WR;
                        w_mem_wdata_nxt = store_merge(bus.mem_rdata, r_wdata,
                                                      r_funct3[0], r_lane);
                    end else begin
                        w_state_nxt      = RESP;
                        w_resp_rdata_nxt = load_ext(bus.mem_rdata, r_funct3, r_lane);
                        w_resp_err_nxt   = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            WR: begin
                w_state_nxt      = RESP;
                w_resp_rdata_nxt = 32'b0;
                w_resp_err_nxt   = 1'b0;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b0;
            r_lane       <= 2'b0;
            r_word_addr  <= '0;
            r_wdata      <= 16'b0;
            r_cnt        <= '0;
            r_mem_wdata  <= 32'b0;
            r_resp_rdata <= 32'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_funct3     <= w_funct3_nxt;
            r_lane       <= w_lane_nxt;
            r_word_addr  <= w_word_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.resp_valid  = (r_state == RESP);
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.resp_err    = r_resp_err;
    assign bus.mem_req     = (r_state == RD_WAIT) || (r_state == WR);
    assign bus.mem_rdwrbar = (r_state != WR);
    assign bus.mem_addr    = r_word_addr;
    assign bus.mem_wdata   = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Directed scoreboard bench for lsu_mem_ctrl with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;
    localparam int ADDR_WIDTH    = 24;
    localparam int WORDS         = 4096;
    localparam int ACCESS_CYCLES = 2;
    localparam int MIDX          = $clog2(WORDS);
    localparam int BOUND         = 20;
    localparam int LAT_ERR       = 1;
    localparam int LAT_SW        = 2;
    localparam int LAT_LD        = ACCESS_CYCLES + 1;
    localparam int LAT_RMW       = ACCESS_CYCLES + 2;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    lsu_mem_ctrl #(
        .WORDS(WORDS), .ADDR_WIDTH(ADDR_WIDTH), .ACCESS_CYCLES(ACCESS_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Single-port memory: registered read, write committed at the clock edge
    logic [31:0] mem [WORDS];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'b0;
            bus.mem_rdata <= 32'b0;
        end else if (bus.mem_req) begin
            if (bus.mem_rdwrbar) bus.mem_rdata <= mem[bus.mem_addr[MIDX-1:0]];
            else                 mem[bus.mem_addr[MIDX-1:0]] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    int                    resp_k;
    int                    wr_k;
    logic                  seen_req;
    logic [31:0]           wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erd, input logic eerr, input int elat);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        sb.push_back('{erd, eerr, elat});
    endtask

    // Entered at the negedge of cycle T+1; leaves at the negedge after RESP
    task automatic observe(input string tag);
        exp_t e;
        logic [31:0] held;
        seen_req = 1'b0;
        wr_k     = 0;
        resp_k   = 0;
        wr_data  = 32'b0;
        wr_addr  = '0;
        for (int k = 1; k <= BOUND; k++) begin
            if (k > 1) @(negedge clk);
            chk({tag, "_ready_busy"}, {31'b0, bus.req_ready}, 32'd0);
            if (bus.mem_req) seen_req = 1'b1;
            if (bus.mem_req && !bus.mem_rdwrbar) begin
                wr_k    = k;
                wr_data = bus.mem_wdata;
                wr_addr = bus.mem_addr;
            end
            if (bus.resp_valid) begin
                resp_k = k;
                break;
            end
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"},   32'(resp_k), 32'(e.lat));
            chk({tag, "_rdata"}, bus.resp_rdata, e.rdata);
            chk({tag, "_err"},   {31'b0, bus.resp_err}, {31'b0, e.err});
        end
        held = bus.resp_rdata;
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, bus.resp_valid}, 32'd0);
        chk({tag, "_hold"},  bus.resp_rdata, held);
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] erd, input logic eerr, input int elat);
        chk({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
        drive(we, f3, addr, wdata, erd, eerr, elat);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'hA5A5A5A5;
        observe(tag);
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_ready"},   {31'b0, bus.req_ready},   32'd1);
        chk({tag, "_mreq"},    {31'b0, bus.mem_req},     32'd0);
        chk({tag, "_rdwr"},    {31'b0, bus.mem_rdwrbar}, 32'd1);
        chk({tag, "_maddr"},   32'(bus.mem_addr),        32'd0);
        chk({tag, "_mwdata"},  bus.mem_wdata,            32'd0);
        chk({tag, "_rvalid"},  {31'b0, bus.resp_valid},  32'd0);
        chk({tag, "_rdata"},   bus.resp_rdata,           32'd0);
        chk({tag, "_rerr"},    {31'b0, bus.resp_err},    32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        mem_clr        = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = 32'b0;
        bus.req_wdata  = 32'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        chk_idle_reset("reset");

        run("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, LAT_SW);
        chk("sw_wr_cyc",  32'(wr_k), 32'd1);
        chk("sw_wr_addr", 32'(wr_addr), 32'd4);
        chk("sw_wr_data", wr_data, 32'hDEADBEEF);

        run("lb",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, LAT_LD);
        chk("lb_no_wr", 32'(wr_k), 32'd0);
        run("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, LAT_LD);

        run("sh", 1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, LAT_RMW);
        chk("sh_wr_cyc",  32'(wr_k), 32'(ACCESS_CYCLES + 1));
        chk("sh_wr_data", wr_data, 32'h1234BEEF);
        chk("sh_wr_addr", 32'(wr_addr), 32'd4);
        run("lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, LAT_LD);
        run("lh",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, LAT_LD);
        run("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00001234, 1'b0, LAT_LD);

        run("sb", 1'b1, 3'b000, 32'h11, 32'hFFFFFFAA, 32'h0, 1'b0, LAT_RMW);
        chk("sb_wr_data", wr_data, 32'h1234AAEF);
        run("lb2", 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, LAT_LD);

        run("err_lw_mis", 1'b0, 3'b010, 32'h11,   32'h0, 32'h0, 1'b1, LAT_ERR);
        chk("err_lw_mis_noreq", {31'b0, seen_req}, 32'd0);
        run("err_sh_mis", 1'b1, 3'b001, 32'h03,   32'hFFFF, 32'h0, 1'b1, LAT_ERR);
        chk("err_sh_mis_noreq", {31'b0, seen_req}, 32'd0);
        run("err_f3",     1'b0, 3'b011, 32'h0,    32'h0, 32'h0, 1'b1, LAT_ERR);
        chk("err_f3_noreq", {31'b0, seen_req}, 32'd0);
        run("err_range",  1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 1'b1, LAT_ERR);
        chk("err_range_noreq", {31'b0, seen_req}, 32'd0);
        run("err_sbu",    1'b1, 3'b100, 32'h20,   32'h77, 32'h0, 1'b1, LAT_ERR);
        chk("err_sbu_noreq", {31'b0, seen_req}, 32'd0);

        run("sw_top", 1'b1, 3'b010, 32'h3FFC, 32'hCAFEF00D, 32'h0, 1'b0, LAT_SW);
        chk("sw_top_addr", 32'(wr_addr), 32'hFFF);
        run("lw_top", 1'b0, 3'b010, 32'h3FFC, 32'h0, 32'hCAFEF00D, 1'b0, LAT_LD);

        // Back-to-back: valid stays high, second request waits for the post-RESP cycle
        chk("b2b_ready0", {31'b0, bus.req_ready}, 32'd1);
        drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, LAT_LD);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000012, 1'b0, LAT_LD);
        observe("b2b_a");
        chk("b2b_ready1", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        observe("b2b_b");

        // Reset during RD_WAIT of a byte store
        chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_in_rdwait", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_idle_reset("rst_mid");
        seen_req = 1'b0;
        resp_k   = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.mem_req)    seen_req = 1'b1;
            if (bus.resp_valid) resp_k   = 1;
            @(negedge clk);
        end
        chk("rst_no_access", {31'b0, seen_req}, 32'd0);
        chk("rst_no_resp",   32'(resp_k), 32'd0);
        run("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, LAT_LD);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
